mac_dot_seq: RTL

Sequencer that drives a `part1`-style signed 8x8→16 multiply-accumulate unit from the operand side. Software or a host block preloads two operand vectors into internal register files. On `start`, the block clears the MAC and streams one operand pair per cycle. It counts the MAC's `valid_out` pulses, then captures and returns the final 16-bit dot product with a one-cycle `done` pulse. It sits between the host write port and the MAC's `valid_in`/`a`/`b` inputs and `f`/`valid_out` outputs.

---
 rtl/mac_dot_seq_if.sv | 42 ++++
 rtl/mac_dot_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mac_dot_seq_if.sv
// rtl/mac_dot_seq_if.sv - host write/start port and MAC operand/result port of mac_dot_seq (optional MAC_SEQ_TIMEOUT_EN adds timeout_err)
interface mac_dot_seq_if #(
    parameter int VEC_LEN = 8,
    parameter int AW      = $clog2(VEC_LEN)
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_a;
    logic [7:0]    wr_b;
    logic          start;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [15:0]   result;
    logic          mac_clear;
    logic          mac_valid_in;
    logic [7:0]    mac_a;
    logic [7:0]    mac_b;
    logic [15:0]   mac_f;
    logic          mac_valid_out;
`ifdef MAC_SEQ_TIMEOUT_EN
    logic          timeout_err;
`endif

    // Host and MAC side, as seen from outside the sequencer.
    modport master (
        output wr_en, wr_addr, wr_a, wr_b, start, len, mac_f, mac_valid_out,
`ifdef MAC_SEQ_TIMEOUT_EN
        input  timeout_err,
`endif
        input  busy, done, result, mac_clear, mac_valid_in, mac_a, mac_b
    );

    // The sequencer itself.
    modport slave (
        input  wr_en, wr_addr, wr_a, wr_b, start, len, mac_f, mac_valid_out,
`ifdef MAC_SEQ_TIMEOUT_EN
        output timeout_err,
`endif
        output busy, done, result, mac_clear, mac_valid_in, mac_a, mac_b
    );
endinterface

// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - operand-side sequencer for a signed 8x8->16 MAC (optional MAC_SEQ_TIMEOUT_EN: DRAIN watchdog)
module mac_dot_seq #(
    parameter int VEC_LEN = 8,
    parameter int AW      = $clog2(VEC_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    mac_dot_seq_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(VEC_LEN);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [7:0]  rf_a [VEC_LEN];
    logic [7:0]  rf_b [VEC_LEN];
    logic [AW:0] eff_len;
    logic [AW:0] issue_cnt;
    logic [AW:0] ret_cnt;
    logic [15:0] result_q;
    logic [AW:0] start_len;
    logic        start_ok;
    logic        wr_ok;
    logic        ret_inc;
    logic        ret_hit;
    logic        drain_fin;
    logic        stream_on;

    // Lengths above the register-file depth are clamped, not wrapped.
    assign start_len = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
    assign start_ok  = (state == S_IDLE) && bus.start;
    assign wr_ok     = bus.wr_en && (state == S_IDLE) && (int'(bus.wr_addr) < VEC_LEN);
    assign ret_inc   = bus.mac_valid_out && ((state == S_STREAM) || (state == S_DRAIN));
    assign ret_hit   = ret_inc && ((ret_cnt + ONE) == eff_len);
    assign drain_fin = ret_hit || (ret_cnt == eff_len);
    assign stream_on = (state == S_STREAM);

`ifdef MAC_SEQ_TIMEOUT_EN
    logic [2:0] wd_cnt;
    logic       wd_fire;
    logic       timeout_q;

    assign wd_fire = (state == S_DRAIN) && !drain_fin && (wd_cnt == 3'd7);

    // Watchdog counts DRAIN cycles; the error flag is only high in the DONE cycle it causes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt    <= (state == S_DRAIN) ? wd_cnt + 3'd1 : 3'd0;
            timeout_q <= wd_fire;
        end
    end

    assign bus.timeout_err = timeout_q;
`endif

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (bus.start) state_nx = (start_len == '0) ? S_DONE : S_CLEAR;
            S_CLEAR:  state_nx = S_STREAM;
            S_STREAM: if (issue_cnt == (eff_len - ONE)) state_nx = S_DRAIN;
`ifdef MAC_SEQ_TIMEOUT_EN
            S_DRAIN:  if (drain_fin || wd_fire) state_nx = S_DONE;
`else
            S_DRAIN:  if (drain_fin) state_nx = S_DONE;
`endif
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Operand register files; writes only land while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                rf_a[i] <= 8'd0;
                rf_b[i] <= 8'd0;
            end
        end else if (wr_ok) begin
            rf_a[bus.wr_addr] <= bus.wr_a;
            rf_b[bus.wr_addr] <= bus.wr_b;
        end
    end

    // Length latch, issue/return counters and result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eff_len   <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            result_q  <= 16'd0;
        end else begin
            if (start_ok) begin
                eff_len <= start_len;
                if (start_len == '0) result_q <= 16'd0;
            end
            if (state == S_CLEAR) begin
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end
            if (stream_on) issue_cnt <= issue_cnt + ONE;
            if (ret_inc) begin
                ret_cnt <= ret_cnt + ONE;
                if (ret_hit) result_q <= bus.mac_f;
            end
        end
    end

    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = (state == S_DONE);
    assign bus.result       = result_q;
    assign bus.mac_clear    = (state == S_CLEAR);
    assign bus.mac_valid_in = stream_on;
    assign bus.mac_a        = stream_on ? rf_a[issue_cnt[AW-1:0]] : 8'd0;
    assign bus.mac_b        = stream_on ? rf_b[issue_cnt[AW-1:0]] : 8'd0;
endmodule
